// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall controller.
// Holds FSM state encoding, default latencies and counter widths.
package pipeline_ctrl_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MD_BUSY = 1'b1
   } md_state_e;

   localparam int MULT_LAT_DEF    = 4;
   localparam int DIV_LAT_DEF     = 32;
   localparam int MEM_TIMEOUT_DEF = 255;

   localparam int WAIT_CNT_W = 8;
   localparam int MD_CNT_W   = 6;

   localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = {WAIT_CNT_W{1'b1}};

   // Counter preload: the start cycle itself is the first stall cycle.
   function automatic logic [MD_CNT_W-1:0] md_load_val(
      input logic is_div,
      input int   mult_lat,
      input int   div_lat
   );
      int lat;
      lat = is_div ? div_lat : mult_lat;
      return MD_CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Combinational load-use hazard compare between the load in EX and the ID sources.
// Zero latency; register 0 never creates a hazard.
module load_use_detector (
   input  logic       i_mem_read,
   input  logic [4:0] i_ex_rt,
   input  logic [4:0] i_id_rs,
   input  logic [4:0] i_id_rt,
   output logic       o_hazard
);

   logic w_dst_nonzero;
   logic w_src_match;

   assign w_dst_nonzero = (i_ex_rt != 5'd0);
   assign w_src_match   = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);
   assign o_hazard      = i_mem_read & w_dst_nonzero & w_src_match;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard controller: memory-wait, mult/div and load-use stalls plus branch flush.
// Outputs are combinational from state and inputs; memory wait overrides every other hazard.
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MULT_LAT    = MULT_LAT_DEF,
   parameter int DIV_LAT     = DIV_LAT_DEF,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] ID_EX_rt,
   input  logic [4:0] IF_ID_rs,
   input  logic [4:0] IF_ID_rt,
   input  logic       MD_Start,
   input  logic       MD_IsDiv,
   input  logic       Branch_Taken,
   input  logic       EX_MEM_MemAccess,
   input  logic       Mem_Ready,
   output logic       PCWrite,
   output logic       IF_ID_Write,
   output logic       ID_EX_Write,
   output logic       EX_MEM_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Flush,
   output logic       EX_MEM_Flush,
   output logic       MEM_WB_Flush,
   output logic       MD_Done,
   output logic       Mem_Timeout
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [MD_CNT_W-1:0]   MD_ONE    = MD_CNT_W'(1);

   md_state_e             r_state;
   md_state_e             w_state_nxt;
   logic [MD_CNT_W-1:0]   r_md_cnt;
   logic [MD_CNT_W-1:0]   w_md_cnt_nxt;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic [WAIT_CNT_W-1:0] w_wait_cnt_nxt;
   logic                  r_mem_timeout;
   logic                  w_mem_timeout_nxt;

   logic w_mem_wait;
   logic w_busy;
   logic w_md_stall;
   logic w_md_last;
   logic w_lu_raw;
   logic w_lu_stall;

   load_use_detector u_load_use (
      .i_mem_read (ID_EX_MemRead),
      .i_ex_rt    (ID_EX_rt),
      .i_id_rs    (IF_ID_rs),
      .i_id_rt    (IF_ID_rt),
      .o_hazard   (w_lu_raw)
   );

   // A reset cycle hides the busy state so an aborted op never shows a stall or MD_Done.
   assign w_mem_wait = EX_MEM_MemAccess & ~Mem_Ready;
   assign w_busy     = (r_state == ST_MD_BUSY) & rst_n;
   assign w_md_stall = ~w_mem_wait & (w_busy | MD_Start);
   assign w_md_last  = w_busy & ~w_mem_wait & (r_md_cnt == MD_ONE);
   assign w_lu_stall = ~w_mem_wait & ~w_busy & ~MD_Start & w_lu_raw;

   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      if (!w_mem_wait) begin
         case (r_state)
            ST_IDLE: begin
               if (MD_Start) begin
                  w_state_nxt  = ST_MD_BUSY;
                  w_md_cnt_nxt = md_load_val(MD_IsDiv, MULT_LAT, DIV_LAT);
               end
            end
            ST_MD_BUSY: begin
               if (r_md_cnt <= MD_ONE) begin
                  w_state_nxt  = ST_IDLE;
                  w_md_cnt_nxt = '0;
               end else begin
                  w_md_cnt_nxt = r_md_cnt - MD_ONE;
               end
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_md_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_wait_cnt_nxt    = '0;
      w_mem_timeout_nxt = r_mem_timeout;
      if (w_mem_wait) begin
         w_wait_cnt_nxt = (r_wait_cnt == WAIT_CNT_MAX) ? r_wait_cnt
                                                       : r_wait_cnt + WAIT_CNT_W'(1);
         if (w_wait_cnt_nxt == TIMEOUT_V) begin
            w_mem_timeout_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_md_cnt      <= '0;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_md_cnt      <= w_md_cnt_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_mem_timeout <= w_mem_timeout_nxt;
      end
   end

   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Flush = 1'b0;
      MEM_WB_Flush = 1'b0;
      if (w_mem_wait) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Flush = 1'b1;
      end else if (w_md_stall) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Flush = 1'b1;
      end else if (w_lu_stall) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Flush  = 1'b1;
      end
   end

   // A taken branch held by a stall is flushed on the first unstalled cycle.
   assign IF_ID_Flush = Branch_Taken & ~w_mem_wait & ~w_md_stall & ~w_lu_stall;
   assign MD_Done     = w_md_last;
   assign Mem_Timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: a reference model queues expected
// outputs per driven cycle, which are popped and compared against the DUT.
module tb_pipeline_stall_controller;

   localparam int MULT_LAT = 4;
   localparam int DIV_LAT  = 32;
   localparam int MEM_TO   = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_rt;
   logic [4:0] IF_ID_rs;
   logic [4:0] IF_ID_rt;
   logic       MD_Start;
   logic       MD_IsDiv;
   logic       Branch_Taken;
   logic       EX_MEM_MemAccess;
   logic       Mem_Ready;
   logic       PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
   logic       IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
   logic       MD_Done, Mem_Timeout;

   always #5 clk = ~clk;

   pipeline_stall_controller #(
      .MULT_LAT    (MULT_LAT),
      .DIV_LAT     (DIV_LAT),
      .MEM_TIMEOUT (MEM_TO)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ID_EX_MemRead    (ID_EX_MemRead),
      .ID_EX_rt         (ID_EX_rt),
      .IF_ID_rs         (IF_ID_rs),
      .IF_ID_rt         (IF_ID_rt),
      .MD_Start         (MD_Start),
      .MD_IsDiv         (MD_IsDiv),
      .Branch_Taken     (Branch_Taken),
      .EX_MEM_MemAccess (EX_MEM_MemAccess),
      .Mem_Ready        (Mem_Ready),
      .PCWrite          (PCWrite),
      .IF_ID_Write      (IF_ID_Write),
      .ID_EX_Write      (ID_EX_Write),
      .EX_MEM_Write     (EX_MEM_Write),
      .IF_ID_Flush      (IF_ID_Flush),
      .ID_EX_Flush      (ID_EX_Flush),
      .EX_MEM_Flush     (EX_MEM_Flush),
      .MEM_WB_Flush     (MEM_WB_Flush),
      .MD_Done          (MD_Done),
      .Mem_Timeout      (Mem_Timeout)
   );

   // [9]PCWrite [8]IF_ID_Write [7]ID_EX_Write [6]EX_MEM_Write [5]IF_ID_Flush
   // [4]ID_EX_Flush [3]EX_MEM_Flush [2]MEM_WB_Flush [1]MD_Done [0]Mem_Timeout
   logic [9:0] w_obs;
   assign w_obs = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush,
                   ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, MD_Done, Mem_Timeout};

   int         n_vec = 0;
   int         n_err = 0;
   logic [9:0] sb_q[$];
   logic [9:0] last_obs;

   int m_md_left = 0;
   int m_wait    = 0;
   bit m_to      = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [9:0] model_out();
      bit mw, busy, mds, lu;
      logic [9:0] v;
      mw   = EX_MEM_MemAccess && !Mem_Ready;
      busy = rst_n && (m_md_left > 0);
      mds  = !mw && (busy || MD_Start);
      lu   = !mw && !busy && !MD_Start && ID_EX_MemRead && (ID_EX_rt != 5'd0) &&
             ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
      v = 10'b1111_0000_00;
      if (mw) begin
         v[9:6] = 4'b0000;
         v[2]   = 1'b1;
      end else if (mds) begin
         v[9:7] = 3'b000;
         v[3]   = 1'b1;
      end else if (lu) begin
         v[9:8] = 2'b00;
         v[4]   = 1'b1;
      end
      v[5] = Branch_Taken && !mw && !mds && !lu;
      v[1] = busy && (m_md_left == 1) && !mw;
      v[0] = m_to;
      return v;
   endfunction

   task automatic model_step();
      bit mw;
      mw = EX_MEM_MemAccess && !Mem_Ready;
      if (!rst_n) begin
         m_md_left = 0;
         m_wait    = 0;
         m_to      = 1'b0;
      end else begin
         if (mw) begin
            if (m_wait < 255) m_wait++;
            if (m_wait == MEM_TO) m_to = 1'b1;
         end else begin
            m_wait = 0;
            if (m_md_left > 0) m_md_left--;
            else if (MD_Start) m_md_left = (MD_IsDiv ? DIV_LAT : MULT_LAT) - 1;
         end
      end
   endtask

   // Called with inputs set just after a falling edge; returns after the next one.
   task automatic cycle(input string tag);
      logic [9:0] exp;
      #1;
      sb_q.push_back(model_out());
      last_obs = w_obs;
      exp = sb_q.pop_front();
      check(tag, {22'd0, last_obs}, {22'd0, exp});
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst_n            = 1'b1;
      ID_EX_MemRead    = 1'b0;
      ID_EX_rt         = 5'd0;
      IF_ID_rs         = 5'd0;
      IF_ID_rt         = 5'd0;
      MD_Start         = 1'b0;
      MD_IsDiv         = 1'b0;
      Branch_Taken     = 1'b0;
      EX_MEM_MemAccess = 1'b0;
      Mem_Ready        = 1'b1;
   endtask

   task automatic run_md(input bit is_div, input int n_cyc, input int mw_from, input int mw_to,
                         output int n_stall, output int done_at);
      n_stall  = 0;
      done_at  = 0;
      MD_Start = 1'b1;
      MD_IsDiv = is_div;
      for (int i = 1; i <= n_cyc; i++) begin
         EX_MEM_MemAccess = (i >= mw_from) && (i <= mw_to);
         Mem_Ready        = !EX_MEM_MemAccess;
         cycle(is_div ? "div_cyc" : "mult_cyc");
         if (!last_obs[9]) n_stall++;
         if (last_obs[1]) done_at = i;
         MD_Start      = 1'b0;
         ID_EX_MemRead = 1'b0;
      end
      idle_inputs();
   endtask

   initial begin
      int ns, dn, pulses;
      idle_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      cycle("reset");
      cycle("reset");
      check("reset_pcwrite", {31'd0, last_obs[9]}, 32'd1);
      rst_n = 1'b1;
      cycle("idle");

      ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
      cycle("lu_rs");
      check("lu_rs_stall", {22'd0, last_obs}, {22'd0, 10'b0011_0100_00});
      ID_EX_MemRead = 1'b0;
      cycle("lu_release");
      check("lu_release_pc", {31'd0, last_obs[9]}, 32'd1);
      ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
      cycle("lu_r0");
      check("lu_r0_pc", {31'd0, last_obs[9]}, 32'd1);
      ID_EX_rt = 5'd9; IF_ID_rs = 5'd3; IF_ID_rt = 5'd9;
      cycle("lu_rt");
      IF_ID_rt = 5'd4;
      cycle("lu_miss");
      idle_inputs();

      run_md(1'b0, 6, 0, 0, ns, dn);
      check("mult_len", ns, MULT_LAT);
      check("mult_done", dn, MULT_LAT);
      run_md(1'b1, 34, 0, 0, ns, dn);
      check("div_len", ns, DIV_LAT);
      check("div_done", dn, DIV_LAT);
      ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
      run_md(1'b0, 6, 0, 0, ns, dn);
      check("md_over_lu_len", ns, MULT_LAT);
      run_md(1'b0, 9, 2, 4, ns, dn);
      check("mult_memwait_done", dn, 7);
      check("mult_memwait_len", ns, 7);

      ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; Branch_Taken = 1'b1;
      cycle("br_lu");
      check("br_held", {31'd0, last_obs[5]}, 32'd0);
      ID_EX_MemRead = 1'b0;
      cycle("br_release");
      check("br_flush", {31'd0, last_obs[5]}, 32'd1);
      idle_inputs();

      EX_MEM_MemAccess = 1'b1; Mem_Ready = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         cycle("memwait");
         if (i == 5) check("timeout_early", {31'd0, last_obs[0]}, 32'd0);
         if (i == 6) check("timeout_set", {31'd0, last_obs[0]}, 32'd1);
      end
      Mem_Ready = 1'b1;
      cycle("timeout_hold");
      cycle("timeout_hold");
      check("timeout_sticky", {31'd0, last_obs[0]}, 32'd1);
      rst_n = 1'b0;
      cycle("timeout_rst");
      rst_n = 1'b1;
      cycle("timeout_clr");
      check("timeout_cleared", {31'd0, last_obs[0]}, 32'd0);
      idle_inputs();

      MD_Start = 1'b1; MD_IsDiv = 1'b1;
      cycle("div_abort");
      MD_Start = 1'b0;
      for (int i = 2; i <= 9; i++) cycle("div_abort");
      rst_n = 1'b0;
      cycle("div_abort_rst");
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         cycle("div_abort_after");
         if (i == 0) check("abort_enables", {28'd0, last_obs[9:6]}, 32'hF);
         if (last_obs[1]) pulses++;
      end
      check("abort_no_done", pulses, 0);

      for (int i = 0; i < 400; i++) begin
         rst_n            = ($urandom_range(63) != 0);
         ID_EX_MemRead    = $urandom_range(1);
         ID_EX_rt         = 5'($urandom_range(3));
         IF_ID_rs         = 5'($urandom_range(3));
         IF_ID_rt         = 5'($urandom_range(3));
         MD_Start         = ($urandom_range(15) == 0);
         MD_IsDiv         = ($urandom_range(3) == 0);
         Branch_Taken     = $urandom_range(1);
         EX_MEM_MemAccess = $urandom_range(1);
         Mem_Ready        = ($urandom_range(3) != 0);
         cycle("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, mult stall cycles, legal range 2..63.
REQ-002 SHALL have parameter DIV_LAT, default 32, div stall cycles, legal range 2..63.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, memory-wait cycles before timeout, legal range 1..255.
REQ-004 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port: ID_EX_MemRead  in  1  instruction in EX is a load.
REQ-007 SHALL have port: ID_EX_rt  in  5  load destination register.
REQ-008 SHALL have port: IF_ID_rs  in  5  source register of instruction in ID.
REQ-009 SHALL have port: IF_ID_rt  in  5  source register of instruction in ID.
REQ-010 SHALL have port: MD_Start  in  1  instruction in EX is mult/div.
REQ-011 SHALL have port: MD_IsDiv  in  1  1 = div, 0 = mult; sampled with MD_Start.
REQ-012 SHALL have port: Branch_Taken  in  1  branch resolved taken in ID.
REQ-013 SHALL have port: EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory.
REQ-014 SHALL have port: Mem_Ready  in  1  data memory completes access this cycle.
REQ-015 SHALL have outputs PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  stage-register load enables; 1 = advance.
REQ-016 SHALL have outputs IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush  out  1 each  load a NOP bubble into that register.
REQ-017 SHALL have port: MD_Done  out  1  one-cycle pulse on the last mult/div stall cycle.
REQ-018 SHALL have port: Mem_Timeout  out  1  sticky memory-wait timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE and MD_BUSY, plus an 8-bit wait counter and a 6-bit MD counter.
REQ-020 MemWait = EX_MEM_MemAccess & ~Mem_Ready; highest priority; SHALL drive all four Write enables 0 and MEM_WB_Flush=1, suppress all other flushes, and freeze the FSM and MD counter.
REQ-021 In MD_BUSY, or in IDLE with MD_Start=1 and MemWait=0: PCWrite=IF_ID_Write=ID_EX_Write=0, EX_MEM_Flush=1, EX_MEM_Write=1.
REQ-022 Entry: IDLE & MD_Start & ~MemWait SHALL load the MD counter with (MD_IsDiv ? DIV_LAT : MULT_LAT)-1 and go to MD_BUSY; each non-MemWait cycle in MD_BUSY decrements it.
REQ-023 MD stall SHALL last exactly LAT non-MemWait cycles, starting with the MD_Start cycle; MD_Done=1 in the last of them (counter==1); next cycle returns to IDLE with all enables 1.
REQ-024 Load-use: in IDLE, with no MemWait or MD_Start, ID_EX_MemRead & ID_EX_rt!=0 & (ID_EX_rt==IF_ID_rs | ID_EX_rt==IF_ID_rt) SHALL give PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 for that single cycle.
REQ-025 MD_Start together with ID_EX_MemRead SHALL be treated as MD; load-use is not evaluated.
REQ-026 IF_ID_Flush SHALL equal Branch_Taken only when no stall of REQ-020/021/024 is active; otherwise 0. A held branch is flushed once the stall releases.
REQ-027 Wait counter SHALL increment (saturating at 255) each MemWait cycle and clear on any non-MemWait cycle; when it reaches MEM_TIMEOUT, Mem_Timeout SHALL set and remain 1 until reset.
REQ-028 With no hazard: all Write enables 1, all flushes 0, MD_Done 0.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, both counters 0, Mem_Timeout 0, including mid-MD or mid-wait; outputs during and after reset follow REQ-028 unless inputs create a hazard.
REQ-030 An MD operation aborted by reset SHALL NOT produce MD_Done.

Structure
REQ-031 Package pipeline_ctrl_pkg SHALL hold the FSM state enum, default latency constants and counter widths.
REQ-032 Load-use compare SHALL be a sub-module load_use_detector (combinational); FSM and counters stay in the top module.

Verification
REQ-033 ID_EX_MemRead=1, ID_EX_rt=8, IF_ID_rs=8 -> exactly 1 cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; ID_EX_rt=0 -> no stall.
REQ-034 MD_Start=1, MD_IsDiv=0 (MULT_LAT=4) -> 4 stall cycles with EX_MEM_Flush=1, MD_Done in cycle 4, enables 1 in cycle 5; MD_IsDiv=1 -> 32 cycles.
REQ-035 Mult in progress; Mem_Ready=0 with EX_MEM_MemAccess=1 for 3 cycles in cycle 2 -> all Writes 0, MEM_WB_Flush=1, MD_Done delayed to cycle 7.
REQ-036 Branch_Taken=1 during load-use stall -> IF_ID_Flush=0 that cycle, 1 the next cycle.
REQ-037 MEM_TIMEOUT=5, Mem_Ready held 0 -> Mem_Timeout rises after 5th wait cycle, stays 1 after Mem_Ready=1; rst_n=0 clears it.
REQ-038 rst_n=0 in cycle 10 of a div -> IDLE next edge, no MD_Done, enables 1.
